pwm_sample_scheduler: RTL and testbench

- Sits between the demodulated audio stream and the PWM output stage.
- Buffers incoming samples in a small FIFO and releases exactly one sample per PWM period on `sample_out`.
- Manages startup priming and underrun recovery, so the PWM always receives a stable, period-aligned value.
- A value of 0 on `sample_out` means midscale (silence), because the PWM stage adds its own offset.

---
 rtl/pwm_sample_scheduler.sv | 170 +++++++++++++++++
 tb/tb_pwm_sample_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_scheduler.sv
// Sample FIFO and scheduler feeding a PWM stage: releases one sample per PWM period,
// with startup priming, underrun hold/timeout and flush-on-disable.
module pwm_sample_scheduler #(
  parameter int unsigned INPUT_WIDTH   = 12,
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned PRIME_LEVEL   = 4,
  parameter int unsigned HOLD_PERIODS  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [INPUT_WIDTH-1:0]        s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [INPUT_WIDTH-1:0]        sample_out,
  output logic                          period_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic                     r_period_tick;
  logic [INPUT_WIDTH-1:0]   r_sample;
  logic                     r_underrun;
  logic                     w_underrun_nxt;
  logic [HW-1:0]            r_hold;
  logic [HW-1:0]            w_hold_nxt;

  logic [INPUT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [LW-1:0]            r_level;

  logic w_tick;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_zero;

  assign w_tick  = (r_cnt == '1);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign s_ready = !w_full && enable && (r_state != ST_IDLE);
  assign w_push  = s_valid && s_ready;

  assign sample_out  = r_sample;
  assign period_tick = r_period_tick;
  assign underrun    = r_underrun;
  assign fifo_level  = r_level;

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_load         = 1'b0;
    w_zero         = 1'b0;
    w_hold_nxt     = r_hold;
    w_underrun_nxt = r_underrun;
    if (!enable) begin
      // Output only falls to silence on the period boundary, never mid-period.
      w_state_nxt    = ST_IDLE;
      w_underrun_nxt = 1'b0;
      w_zero         = w_tick;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_PRIME;
          w_zero      = w_tick;
        end
        ST_PRIME: begin
          w_zero = w_tick;
          if (w_tick && (r_level >= LW'(PRIME_LEVEL))) begin
            w_state_nxt    = ST_RUN;
            w_underrun_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            if (!w_empty) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_state_nxt    = ST_HOLD;
              w_hold_nxt     = HW'(1);
              w_underrun_nxt = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            if (!w_empty) begin
              w_pop          = 1'b1;
              w_load         = 1'b1;
              w_state_nxt    = ST_RUN;
              w_underrun_nxt = 1'b0;
            end else if (r_hold >= HW'(HOLD_PERIODS)) begin
              w_zero      = 1'b1;
              w_state_nxt = ST_PRIME;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_underrun    <= 1'b0;
      r_sample      <= '0;
    end else begin
      r_cnt         <= r_cnt + 1'b1;
      r_period_tick <= w_tick;
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_underrun    <= w_underrun_nxt;
      if (w_load) begin
        r_sample <= r_mem[r_rd_ptr];
      end else if (w_zero) begin
        r_sample <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (!enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: priming, backpressure, underrun hold and
// timeout, disable flush and asynchronous reset, all with hand-computed expectations.
`timescale 1ns/100ps
module tb_pwm_sample_scheduler;

  localparam int unsigned IW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [IW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] sample_out;
  logic          period_tick;
  logic          underrun;
  logic [3:0]    fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_tick = 0;
  int spacing = 0;

  pwm_sample_scheduler #(
    .INPUT_WIDTH  (IW),
    .COUNTER_WIDTH(10),
    .FIFO_DEPTH   (8),
    .PRIME_LEVEL  (4),
    .HOLD_PERIODS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .sample_out (sample_out),
    .period_tick(period_tick),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      if (period_tick) seen = 1'b1;
    end
    check("tick_seen", 32'(seen), 32'd1);
    spacing   = cyc - last_tick;
    last_tick = cyc;
  endtask

  task automatic push(input logic [IW-1:0] d);
    for (int i = 0; i < 2100 && !s_ready; i++) @(negedge clk);
    check("push_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int seq [7] = '{300, 400, 500, 600, 700, 800, 900};
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sample", sample_out, 0);
    check("rst_tick", period_tick, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 0);
    rst = 1'b0;

    // Priming
    @(negedge clk);
    enable = 1'b1;
    push(12'd100); push(12'd200); push(12'd300); push(12'd400);
    check("prime_level", fifo_level, 4);
    check("prime_out", sample_out, 0);
    wait_tick();
    check("prime_tick_out", sample_out, 0);
    wait_tick();
    check("run_100", sample_out, 100);
    check("spacing_a", spacing, 1024);

    // Backpressure
    push(12'd500); push(12'd600); push(12'd700); push(12'd800); push(12'd900);
    check("full_level", fifo_level, 8);
    check("full_ready", s_ready, 0);
    s_valid = 1'b1; s_data = 12'd999;
    repeat (3) @(negedge clk);
    check("full_reject", fifo_level, 8);
    s_valid = 1'b0;
    wait_tick();
    check("run_200", sample_out, 200);
    check("after_full_level", fifo_level, 7);
    check("after_full_ready", s_ready, 1);
    check("spacing_b", spacing, 1024);
    for (int i = 0; i < 7; i++) begin
      wait_tick();
      check("run_seq", sample_out, seq[i]);
    end
    check("spacing_c", spacing, 1024);

    // Underrun recovery
    wait_tick();
    check("ur_flag", underrun, 1);
    check("ur_held", sample_out, 900);
    push(12'h7FF);
    wait_tick();
    check("ur_recover", sample_out, 12'h7FF);
    check("ur_clear", underrun, 0);

    // Underrun timeout
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      check("to_held", sample_out, 12'h7FF);
      check("to_flag", underrun, 1);
    end
    wait_tick();
    check("to_silence", sample_out, 0);
    check("to_flag_prime", underrun, 1);
    check("to_ready_prime", s_ready, 1);
    push(12'h001); push(12'h800); push(12'hFFF); push(12'h123);
    wait_tick();
    check("resume_zero", sample_out, 0);
    check("resume_clear", underrun, 0);
    wait_tick(); check("resume_001", sample_out, 12'h001);
    wait_tick(); check("resume_800", sample_out, 12'h800);
    wait_tick(); check("resume_fff", sample_out, 12'hFFF);

    // Disable with 5 queued
    push(12'h00A); push(12'h00B); push(12'h00C); push(12'h00D);
    check("dis_level_pre", fifo_level, 5);
    enable = 1'b0;
    @(negedge clk);
    check("dis_flush", fifo_level, 0);
    check("dis_ready", s_ready, 0);
    check("dis_underrun", underrun, 0);
    check("dis_out_kept", sample_out, 12'hFFF);
    wait_tick();
    check("dis_out_zero", sample_out, 0);

    // Async reset during RUN
    enable = 1'b1;
    push(12'h111); push(12'h222); push(12'h333); push(12'h444);
    wait_tick(); check("re_prime", sample_out, 0);
    wait_tick(); check("re_111", sample_out, 12'h111);
    @(negedge clk);
    #2 rst = 1'b1;
    #0.5;
    check("arst_sample", sample_out, 0);
    check("arst_level", fifo_level, 0);
    check("arst_underrun", underrun, 0);
    check("arst_tick", period_tick, 0);
    check("arst_ready", s_ready, 0);
    #0.5 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
